// File: rtl/restador_serie_n_if.sv
// Operand/result handshake bundle for restador_serie_n.
// Modo exists only when RESTADOR_SERIE_MODO_SUMA_EN is defined.
interface restador_serie_n_if #(
    parameter int ANCHO = 8
);
    logic [ANCHO-1:0] X;
    logic [ANCHO-1:0] Y;
    logic             CarrieNEntrada;
    logic             EntradaValida;
    logic             EntradaLista;
    logic [ANCHO-1:0] R;
    logic             CarrieNSalida;
    logic             Desborde;
    logic             SalidaValida;
    logic             SalidaLista;
`ifdef RESTADOR_SERIE_MODO_SUMA_EN
    logic             Modo;
`endif

    modport master (
`ifdef RESTADOR_SERIE_MODO_SUMA_EN
        output Modo,
`endif
        output X, Y, CarrieNEntrada, EntradaValida, SalidaLista,
        input  EntradaLista, R, CarrieNSalida, Desborde, SalidaValida
    );

    modport slave (
`ifdef RESTADOR_SERIE_MODO_SUMA_EN
        input  Modo,
`endif
        input  X, Y, CarrieNEntrada, EntradaValida, SalidaLista,
        output EntradaLista, R, CarrieNSalida, Desborde, SalidaValida
    );
endinterface

// File: rtl/restador_serie_n.sv
// Multi-cycle ANCHO-bit subtractor resolving BITS_POR_CICLO bits per clock, LSB slice first.
// Define RESTADOR_SERIE_MODO_SUMA_EN to add the Modo input (Modo=1 selects addition).
module restador_serie_n #(
    parameter int ANCHO          = 8,
    parameter int BITS_POR_CICLO = 1
) (
    input logic               Clk,
    input logic               Rst_n,
    restador_serie_n_if.slave bus
);
    localparam int            N      = ANCHO / BITS_POR_CICLO;
    localparam int            CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ULTIMA = CW'(N - 1);

    generate
        if (ANCHO < 2) begin : gAnchoInvalido
            $error("restador_serie_n: ANCHO must be at least 2");
        end
        if (BITS_POR_CICLO < 1 || (ANCHO % BITS_POR_CICLO) != 0) begin : gCorteInvalido
            $error("restador_serie_n: BITS_POR_CICLO must divide ANCHO exactly");
        end
    endgenerate

    typedef enum logic [1:0] {REPOSO, CALCULO, RESULTADO} EstadoFsm;

    EstadoFsm                  estado, estadoSig;
    logic [ANCHO-1:0]          xReg, yReg, rReg;
    logic                      prestamo, carrieReg, desbordeReg;
    logic [CW-1:0]             contador;
    logic                      modoSuma;
    logic [BITS_POR_CICLO-1:0] xCorte, yCorte, rCorte;
    logic                      prestamoCorte, desbordeFinal, ultimo, aceptar;
    logic                      entradaLista, salidaValida;

    assign aceptar = entradaLista && bus.EntradaValida;
    assign ultimo  = (contador == ULTIMA);

    // NOTE: operand registers are always loaded at acceptance before being read, so they carry no reset.
    always_ff @(posedge Clk) begin
        if (aceptar) begin
            xReg <= bus.X;
            yReg <= bus.Y;
        end
    end

`ifdef RESTADOR_SERIE_MODO_SUMA_EN
    logic modoReg;

    always_ff @(posedge Clk) begin
        if (aceptar) begin
            modoReg <= bus.Modo;
        end
    end

    assign modoSuma = modoReg;
`else
    assign modoSuma = 1'b0;
`endif

    // One slice of the ripple chain: full subtractor, or full adder in sum mode.
    always_comb begin
        logic cadena;
        xCorte = xReg[contador*BITS_POR_CICLO +: BITS_POR_CICLO];
        yCorte = yReg[contador*BITS_POR_CICLO +: BITS_POR_CICLO];
        rCorte = '0;
        cadena = prestamo;
        for (int i = 0; i < BITS_POR_CICLO; i++) begin
            rCorte[i] = xCorte[i] ^ yCorte[i] ^ cadena;
            if (modoSuma) begin
                cadena = (xCorte[i] & yCorte[i]) | ((xCorte[i] ^ yCorte[i]) & cadena);
            end else begin
                cadena = (~xCorte[i] & yCorte[i]) | (~(xCorte[i] ^ yCorte[i]) & cadena);
            end
        end
        prestamoCorte = cadena;
    end

    // Meaningful only on the last slice, whose top bit is the result MSB.
    assign desbordeFinal = modoSuma
        ? ((xReg[ANCHO-1] == yReg[ANCHO-1]) && (rCorte[BITS_POR_CICLO-1] != xReg[ANCHO-1]))
        : ((xReg[ANCHO-1] != yReg[ANCHO-1]) && (rCorte[BITS_POR_CICLO-1] != xReg[ANCHO-1]));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estadoSig;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        estadoSig    = estado;
        entradaLista = 1'b0;
        salidaValida = 1'b0;
        case (estado)
            REPOSO: begin
                entradaLista = 1'b1;
                if (bus.EntradaValida) estadoSig = CALCULO;
            end
            CALCULO: begin
                if (ultimo) estadoSig = RESULTADO;
            end
            RESULTADO: begin
                salidaValida = 1'b1;
                if (bus.SalidaLista) estadoSig = REPOSO;
            end
            default: estadoSig = REPOSO;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rReg        <= '0;
            carrieReg   <= 1'b0;
            desbordeReg <= 1'b0;
            prestamo    <= 1'b0;
            contador    <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.EntradaValida) begin
                        rReg     <= '0;
                        contador <= '0;
                        prestamo <= bus.CarrieNEntrada;
                    end
                end
                CALCULO: begin
                    rReg[contador*BITS_POR_CICLO +: BITS_POR_CICLO] <= rCorte;
                    prestamo <= prestamoCorte;
                    contador <= contador + 1'b1;
                    if (ultimo) begin
                        carrieReg   <= prestamoCorte;
                        desbordeReg <= desbordeFinal;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.EntradaLista  = entradaLista;
    assign bus.SalidaValida  = salidaValida;
    assign bus.R             = rReg;
    assign bus.CarrieNSalida = carrieReg;
    assign bus.Desborde      = desbordeReg;
endmodule

// File: doc/restador_serie_n.md
Name: restador_serie_n

Overview:
Parametrised multi-cycle N-bit subtractor built around a borrow chain.
- Per cycle it processes a slice of BITS_POR_CICLO bits (LSB first) with the full-subtractor equations, and holds the borrow in a register between slices.
- Operands enter and results leave through a valid/ready handshake.
- Used as a small-area arithmetic unit in datapaths where a wide combinational subtractor is too costly.

Parameters:
ANCHO, 8, operand/result width in bits; must be ≥ 2.
BITS_POR_CICLO, 1, bits resolved per clock; must divide ANCHO exactly (elaboration error otherwise).

Ports:
Clk  input  1  clock, rising-edge.
Rst_n  input  1  reset, synchronous, active-low.
X  input  ANCHO  minuend.
Y  input  ANCHO  subtrahend.
CarrieNEntrada  input  1  borrow-in applied to slice 0.
EntradaValida  input  1  operands valid.
EntradaLista  output  1  block can accept operands.
R  output  ANCHO  difference, X − Y − CarrieNEntrada mod 2^ANCHO.
CarrieNSalida  output  1  final borrow-out (unsigned X < Y + CarrieNEntrada).
Desborde  output  1  signed overflow: X[MSB] ≠ Y[MSB] and R[MSB] ≠ X[MSB].
SalidaValida  output  1  result valid.
SalidaLista  input  1  consumer ready.

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-low on Rst_n, sampled only on a rising Clk edge.
- Reset values: state=REPOSO, R=0, CarrieNSalida=0, Desborde=0, SalidaValida=0, EntradaLista=1, internal borrow=0, slice counter=0.
- Let N = ANCHO/BITS_POR_CICLO.
- FSM states: REPOSO, CALCULO, RESULTADO.
- REPOSO:
  - EntradaLista=1.
  - On an edge with EntradaValida=1: latch X, Y and CarrieNEntrada into internal registers, clear R, set the counter to 0, load borrow=CarrieNEntrada, go to CALCULO.
- CALCULO:
  - EntradaLista=0.
  - Each edge computes slice i: bits [i·B+B−1 : i·B], with B = BITS_POR_CICLO.
  - Slice rule: per bit, R = x^y^b and b_next = (~x&y)|(~(x^y)&b), chained ripple-fashion inside the slice.
  - Each edge writes the slice result into R and stores the slice borrow-out.
  - On the edge processing slice N−1: register CarrieNSalida and Desborde, then go to RESULTADO.
- Latency: operands accepted at edge k → SalidaValida=1 after edge k+N.
  - Examples: ANCHO=8/B=1 → 8 cycles; ANCHO=8/B=4 → 2 cycles.
- RESULTADO:
  - SalidaValida=1. R, CarrieNSalida and Desborde are stable and held while SalidaLista=0, with no limit on the stall.
  - On an edge with SalidaLista=1: SalidaValida→0, go to REPOSO.
  - The next operands can be accepted no earlier than the following edge. EntradaLista=0 throughout RESULTADO.
- Input stability: X/Y/CarrieNEntrada changing during CALCULO/RESULTADO has no effect, because the operands were latched at acceptance.
- Reset mid-operation: Rst_n=0 on any edge aborts immediately to the reset values; the partial result is discarded.
- Visibility of R: R is internal-only while SalidaValida=0; its value in that window is not checked by the bench except after reset, where it must be 0.

Optional Feature:
Macro RESTADOR_SERIE_MODO_SUMA_EN.
- Defined:
  - Adds input port Modo (1 bit), latched with the operands.
  - Modo=0: subtraction exactly as above.
  - Modo=1: addition, R = X + Y + CarrieNEntrada mod 2^ANCHO. CarrieNSalida is the carry-out. Desborde = X[MSB]=Y[MSB] and R[MSB]≠X[MSB].
  - Latency and handshake are unchanged.
- Not defined: the Modo port is absent; the block is subtract-only.

Test Plan:
1. ANCHO=8, B=1: X=0x05, Y=0x03, Bin=0 → after 8 cycles R=0x02, CarrieNSalida=0, Desborde=0, SalidaValida=1.
2. ANCHO=8, B=1: X=0x00, Y=0x01, Bin=0 → R=0xFF, CarrieNSalida=1, Desborde=0. X=0x80, Y=0x01 → R=0x7F, CarrieNSalida=0, Desborde=1.
3. ANCHO=8, B=4: X=0x10, Y=0x0F, Bin=1 → SalidaValida 2 cycles after acceptance, R=0x00, CarrieNSalida=0.
4. Backpressure: hold SalidaLista=0 for 5 cycles in RESULTADO → R and flags constant, EntradaLista=0. Then assert SalidaLista → REPOSO next cycle. A new operand pair is accepted on the following edge.
5. Reset mid-op: Rst_n=0 at the 4th CALCULO cycle → next edge shows R=0, SalidaValida=0, EntradaLista=1. A subsequent 0x0A−0x0B computes 0xFF with borrow=1 correctly.
6. With RESTADOR_SERIE_MODO_SUMA_EN, Modo=1: X=0xFF, Y=0x01, Bin=0 → R=0x00, CarrieNSalida=1, Desborde=0. X=0x7F, Y=0x01 → R=0x80, Desborde=1.
